// File: rtl/frv_sram_port_if.sv
// Split-transaction memory bus between frv_core (master) and a memory responder (slave).
// Request phase is req/gnt, response phase is recv/ack.
interface frv_sram_port_if;
    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );
endinterface

// File: rtl/frv_sram_port.sv
// Word-addressed SRAM responder with a small in-order response FIFO.
// Define FRV_SRAM_WAIT_EN to add LFSR-driven pseudo-random request stalls.
module frv_sram_port #(
    parameter int unsigned MEM_AW    = 10,
    parameter int unsigned RSP_DEPTH = 2,
    parameter logic [31:0] LFSR_SEED = 32'h1
) (
    input logic            g_clk,
    input logic            g_resetn,
    frv_sram_port_if.slave mem
);
    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } rsp_t;

    if (RSP_DEPTH != 2 && RSP_DEPTH != 4) begin : g_bad_depth
        $error("frv_sram_port: RSP_DEPTH must be 2 or 4");
    end

    rsp_t          fifo_q [RSP_DEPTH];
    rsp_t          fifo_d [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   sram_q [2**MEM_AW];

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              addr_err;
    logic [MEM_AW-1:0] word_idx;
    rsp_t              push_rsp;
    rsp_t              head_rsp;
    logic              unused_ok;

    assign word_idx   = mem.mem_addr[MEM_AW+1:2];
    assign addr_err   = |mem.mem_addr[31:MEM_AW+2];
    assign fifo_full  = (count_q == CW'(RSP_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign unused_ok  = ^{mem.mem_addr[1:0], LFSR_SEED};

`ifdef FRV_SRAM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) lfsr_q <= LFSR_SEED[15:0];
        else           lfsr_q <= lfsr_d;
    end

    assign mem.mem_gnt = g_resetn && !fifo_full && !lfsr_q[0];
`else
    // Grant depends only on registered state, so ack cannot ripple into gnt.
    assign mem.mem_gnt = g_resetn && !fifo_full;
`endif

    assign push = mem.mem_req && mem.mem_gnt;
    assign pop  = mem.mem_recv && mem.mem_ack;

    // Writes and out-of-range reads both answer with zero data.
    always_comb begin
        push_rsp.error = addr_err;
        push_rsp.rdata = (mem.mem_wen || addr_err) ? 32'h0 : sram_q[word_idx];
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_rsp;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the array has no reset so it maps onto SRAM and survives a mid-run reset.
    always_ff @(posedge g_clk) begin
        if (push && mem.mem_wen && !addr_err) begin
            for (int i = 0; i < 4; i++) begin
                if (mem.mem_strb[i]) sram_q[word_idx][8*i +: 8] <= mem.mem_wdata[8*i +: 8];
            end
        end
    end

    assign head_rsp      = fifo_q[rd_ptr_q];
    assign mem.mem_recv  = !fifo_empty;
    assign mem.mem_error = !fifo_empty && head_rsp.error;
    assign mem.mem_rdata = fifo_empty ? 32'h0 : head_rsp.rdata;
endmodule
